// File: rtl/reg_file_pkg.sv
// Shared opcode constants and decode-class helpers for the register file / scoreboard.
package reg_file_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        case (op)
            OP_R, OP_STORE, OP_BRANCH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy scoreboard: tracks in-flight writebacks and raises stall on RAW/WAW hazards.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter  int NUM_REGS = 32,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                i_issue_valid,
    input  logic [6:0]          i_opcode,
    input  logic [ADDR_W-1:0]   i_rs1_addr,
    input  logic [ADDR_W-1:0]   i_rs2_addr,
    input  logic [ADDR_W-1:0]   i_rd_addr,
    input  logic                i_wb_valid,
    input  logic [ADDR_W-1:0]   i_wb_addr,
    input  logic                i_fwd1,
    input  logic                i_fwd2,
    output logic                o_stall,
    output logic [NUM_REGS-1:0] o_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic                w_writes;
    logic                w_raw1;
    logic                w_raw2;
    logic                w_waw;
    logic                w_stall;
    logic                w_set;

    always_comb begin
        w_writes = writes_rd(i_opcode);
        w_raw1   = uses_rs1(i_opcode) & r_busy[i_rs1_addr] & ~i_fwd1;
        w_raw2   = uses_rs2(i_opcode) & r_busy[i_rs2_addr] & ~i_fwd2;
        // A writeback retiring the old producer of rd removes the WAW conflict this cycle.
        w_waw    = w_writes & r_busy[i_rd_addr] & ~(i_wb_valid & (i_wb_addr == i_rd_addr));
        w_stall  = i_issue_valid & (w_raw1 | w_raw2 | w_waw);
        w_set    = i_issue_valid & ~w_stall & w_writes & (i_rd_addr != '0);
    end

    // The set is ordered after the clear so a new producer wins over the retiring one.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            if (i_wb_valid)
                r_busy[i_wb_addr] <= 1'b0;
            if (w_set)
                r_busy[i_rd_addr] <= 1'b1;
        end
    end

    assign o_stall = w_stall;
    assign o_busy  = r_busy;

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with two combinational reads, one registered write, busy scoreboard and
// I-type operand-B select. Define REG_FILE_BYPASS_EN for same-cycle writeback-to-read forwarding.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter  int XLEN     = 32,
    parameter  int NUM_REGS = 32,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [6:0]          opcode,
    input  logic [ADDR_W-1:0]   rs1_addr,
    input  logic [ADDR_W-1:0]   rs2_addr,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [11:0]         imm_in,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    output logic [XLEN-1:0]     data1,
    output logic [XLEN-1:0]     data2,
    output logic [XLEN-1:0]     op_b,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy
);

    logic [XLEN-1:0] r_regs [NUM_REGS];
    logic            w_fwd1;
    logic            w_fwd2;
    logic [XLEN-1:0] w_data1;
    logic [XLEN-1:0] w_data2;
    logic [XLEN-1:0] w_imm_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else if (wb_valid && (wb_addr != '0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        w_fwd1 = 1'b0;
        w_fwd2 = 1'b0;
`ifdef REG_FILE_BYPASS_EN
        w_fwd1 = wb_valid && (wb_addr == rs1_addr) && (rs1_addr != '0);
        w_fwd2 = wb_valid && (wb_addr == rs2_addr) && (rs2_addr != '0);
`endif
        if (rs1_addr == '0)
            w_data1 = '0;
        else
            w_data1 = w_fwd1 ? wb_data : r_regs[rs1_addr];
        if (rs2_addr == '0)
            w_data2 = '0;
        else
            w_data2 = w_fwd2 ? wb_data : r_regs[rs2_addr];
        w_imm_ext = {{(XLEN-12){imm_in[11]}}, imm_in};
    end

    reg_scoreboard #(
        .NUM_REGS(NUM_REGS)
    ) u_sb (
        .clk          (clk),
        .i_rst_n      (reset),
        .i_issue_valid(issue_valid),
        .i_opcode     (opcode),
        .i_rs1_addr   (rs1_addr),
        .i_rs2_addr   (rs2_addr),
        .i_rd_addr    (rd_addr),
        .i_wb_valid   (wb_valid),
        .i_wb_addr    (wb_addr),
        .i_fwd1       (w_fwd1),
        .i_fwd2       (w_fwd2),
        .o_stall      (stall),
        .o_busy       (busy)
    );

    assign data1 = w_data1;
    assign data2 = w_data2;
    assign op_b  = (opcode == OP_IMM) ? w_imm_ext : w_data2;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vector table, hand-written hazard sequences, random vs. model.
module tb_reg_file_sb;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              issue_valid;
    logic [31:0]       instr;
    logic [6:0]        opcode;
    logic [ADDR_W-1:0] rs1_addr, rs2_addr, rd_addr;
    logic [11:0]       imm_in;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic [XLEN-1:0]   data1, data2, op_b;
    logic              stall;
    logic [NUM_REGS-1:0] busy;

    assign opcode   = instr[6:0];
    assign rd_addr  = instr[11:7];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign imm_in   = instr[31:20];

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .opcode(opcode),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .imm_in(imm_in),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .data1(data1), .data2(data2), .op_b(op_b), .stall(stall), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] ob, input logic st, input logic [31:0] bz);
        chk({tag, ".data1"}, data1, d1);
        chk({tag, ".data2"}, data2, d2);
        chk({tag, ".op_b"},  op_b,  ob);
        chk({tag, ".stall"}, {31'b0, stall}, {31'b0, st});
        chk({tag, ".busy"},  busy,  bz);
    endtask

    task automatic drive(input logic iv, input logic [31:0] ins, input logic wbv,
                         input logic [4:0] wba, input logic [31:0] wbd);
        issue_valid = iv;
        instr       = ins;
        wb_valid    = wbv;
        wb_addr     = wba;
        wb_data     = wbd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] ins;
        logic        wbv;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic [31:0] d1, d2, ob;
        logic        st;
        logic [31:0] bz;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(input logic iv, input logic [31:0] ins, input logic wbv,
                                input logic [4:0] wba, input logic [31:0] wbd,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] ob, input logic st, input logic [31:0] bz);
        vec_t v;
        v.iv = iv; v.ins = ins; v.wbv = wbv; v.wba = wba; v.wbd = wbd;
        v.d1 = d1; v.d2 = d2; v.ob = ob; v.st = st; v.bz = bz;
        return v;
    endfunction

    // Reference model: architectural contents and the set of registers with a pending producer.
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    function automatic bit m_writes(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
                          7'b1100111, 7'b0110111, 7'b0010111};
    endfunction
    function automatic bit m_uses1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                          7'b1100011, 7'b1100111};
    endfunction
    function automatic bit m_uses2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        if (idx == 0) return 32'd0;
        if (BYP && wb_valid && int'(wb_addr) == idx) return wb_data;
        return m_regs[idx];
    endfunction

    function automatic bit m_stall();
        int  r1 = int'(rs1_addr);
        int  r2 = int'(rs2_addr);
        int  rd = int'(rd_addr);
        bit  f1 = BYP && wb_valid && int'(wb_addr) == r1 && r1 != 0;
        bit  f2 = BYP && wb_valid && int'(wb_addr) == r2 && r2 != 0;
        bit  h1 = m_uses1(opcode) && m_busy[r1] && !f1;
        bit  h2 = m_uses2(opcode) && m_busy[r2] && !f2;
        bit  hw = m_writes(opcode) && m_busy[rd] && !(wb_valid && int'(wb_addr) == rd);
        return issue_valid && (h1 || h2 || hw);
    endfunction

    logic [6:0] ops [10];

    initial begin
        logic [31:0] e1, e2, eb, ins;
        bit          est;
        int          wsel, start;

        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
        ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b1100111; ops[7] = 7'b0110111;
        ops[8] = 7'b0010111; ops[9] = 7'b1110011;

        tbl[0] = mk(0, 32'h0,        1, 1, 32'd10, 0,  0,  0,  0, 32'h0);
        tbl[1] = mk(0, 32'h0,        1, 2, 32'd11, 0,  0,  0,  0, 32'h0);
        tbl[2] = mk(1, 32'h00208033, 0, 0, 32'h0,  10, 11, 11, 0, 32'h0);
        tbl[3] = mk(0, 32'h00208033, 1, 0, 32'hFF, 10, 11, 11, 0, 32'h0);
        tbl[4] = mk(0, 32'h00000033, 0, 0, 32'h0,  0,  0,  0,  0, 32'h0);
        tbl[5] = mk(1, 32'h003110b3, 0, 0, 32'h0,  11, 0,  0,  0, 32'h0);
        tbl[6] = mk(1, 32'h0041a133, 0, 0, 32'h0,  0,  0,  0,  0, 32'h2);
        tbl[7] = mk(0, 32'h0,        1, 2, 32'h22, 0,  0,  0,  0, 32'h6);
        tbl[8] = mk(1, 32'h00108133, 0, 0, 32'h0,  10, 10, 10, 1, 32'h2);
        tbl[9] = mk(1, 32'h00108133, 0, 0, 32'h0,  10, 10, 10, 1, 32'h2);

        reset = 1'b0;
        drive(0, 32'h00208033, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        expect_all("in_reset", 0, 0, 0, 0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        expect_all("post_reset", 0, 0, 0, 0, 32'h0);
        next_cycle();

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].iv, tbl[i].ins, tbl[i].wbv, tbl[i].wba, tbl[i].wbd);
            @(negedge clk);
            expect_all($sformatf("vec%0d", i), tbl[i].d1, tbl[i].d2, tbl[i].ob, tbl[i].st, tbl[i].bz);
            next_cycle();
        end

        // RAW release: writeback of x1 while the dependent add is waiting.
        drive(1, 32'h00108133, 1, 1, 32'd13);
        @(negedge clk);
        if (BYP) expect_all("raw_wb", 13, 13, 13, 0, 32'h2);
        else     expect_all("raw_wb", 10, 10, 10, 1, 32'h2);
        next_cycle();
        if (!BYP) begin
            drive(1, 32'h00108133, 0, 0, 0);
            @(negedge clk);
            expect_all("raw_after", 13, 13, 13, 0, 32'h0);
            next_cycle();
        end
        drive(0, 32'h0, 1, 2, 32'h22);
        @(negedge clk);
        expect_all("raw_issued", 0, 0, 0, 0, 32'h4);
        next_cycle();

        // WAW stall and set-wins on the same index.
        drive(1, 32'h000001b3, 0, 0, 0);
        @(negedge clk);
        expect_all("waw_first", 0, 0, 0, 0, 32'h0);
        next_cycle();
        drive(1, 32'h000001b3, 0, 0, 0);
        @(negedge clk);
        expect_all("waw_stall", 0, 0, 0, 1, 32'h8);
        next_cycle();
        drive(1, 32'h000001b3, 1, 3, 32'h33);
        @(negedge clk);
        expect_all("waw_wb", 0, 0, 0, 0, 32'h8);
        next_cycle();
        drive(0, 32'h00018033, 0, 0, 0);
        @(negedge clk);
        expect_all("set_wins", 32'h33, 0, 0, 0, 32'h8);
        next_cycle();
        drive(0, 32'h0, 1, 3, 32'h34);
        next_cycle();

        // Immediate operand select.
        drive(1, 32'hffba8a13, 0, 0, 0);
        @(negedge clk);
        expect_all("addi_neg", 0, 0, 32'hFFFFFFFB, 0, 32'h0);
        next_cycle();
        drive(1, 32'h00aa0993, 0, 0, 0);
        @(negedge clk);
        expect_all("addi_pos", 0, 0, 32'h0000000A, 1, 32'h00100000);
        next_cycle();
        drive(0, 32'h0, 1, 20, 32'h77);
        next_cycle();

        // Asynchronous reset in the middle of a cycle.
        drive(1, 32'h000001b3, 1, 5, 32'h2A);
        next_cycle();
        drive(0, 32'h00028033, 0, 0, 0);
        @(negedge clk);
        expect_all("pre_rst", 32'h2A, 0, 0, 0, 32'h8);
        #2;
        reset = 1'b0;
        #1;
        expect_all("mid_rst", 0, 0, 0, 0, 32'h0);
        next_cycle();
        reset = 1'b1;
        drive(0, 32'h00028033, 1, 5, 32'h55);
        next_cycle();
        drive(0, 32'h00028033, 0, 0, 0);
        @(negedge clk);
        expect_all("wb_after_rst", 32'h55, 0, 0, 0, 32'h0);
        next_cycle();

        // Randomized phase against the model, starting from a fresh reset.
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_busy = 32'd0;

        for (int n = 0; n < 600; n++) begin
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 9)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            wsel = $urandom_range(0, 7);
            if (m_busy != 0 && $urandom_range(0, 2) != 0) begin
                start = $urandom_range(0, 7);
                for (int k = 0; k < 8; k++) begin
                    if (m_busy[(start + k) % 8]) begin
                        wsel = (start + k) % 8;
                        break;
                    end
                end
            end
            drive($urandom_range(0, 3) != 0, ins, 1'($urandom_range(0, 1)), 5'(wsel), $urandom);

            e1  = m_read(int'(rs1_addr));
            e2  = m_read(int'(rs2_addr));
            eb  = (opcode == 7'b0010011) ? {{20{imm_in[11]}}, imm_in} : e2;
            est = m_stall();
            @(negedge clk);
            expect_all($sformatf("rnd%0d", n), e1, e2, eb, est, m_busy);

            @(posedge clk);
            if (wb_valid) begin
                if (wb_addr != 0) m_regs[wb_addr] = wb_data;
                m_busy[wb_addr] = 1'b0;
            end
            if (issue_valid && !est && m_writes(opcode) && rd_addr != 0)
                m_busy[rd_addr] = 1'b1;
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
